// File: rtl/matvec_pkg.sv
// Shared sizes, saturation limits and driver state encoding for the
// 3x3 matrix-vector stream driver.
package matvec_pkg;

   localparam int WIDTH  = 14;
   localparam int SIZE_X = 3;
   localparam int SIZE_W = 9;
   localparam int ROWS   = SIZE_W / SIZE_X;
   localparam int N_OPS  = SIZE_W + SIZE_X;
   localparam int ADDR_W = $clog2(N_OPS);
   localparam int RES_W  = 2 * WIDTH;

   localparam logic signed [RES_W-1:0] ACC_MAX = {1'b0, {(RES_W-1){1'b1}}};
   localparam logic signed [RES_W-1:0] ACC_MIN = {1'b1, {(RES_W-1){1'b0}}};

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RECV = 2'd2
   } drv_state_t;

endpackage

// File: rtl/matvec3_operand_buf.sv
// Operand register file: W row-major at 0..8, x at 9..11.
// One synchronous write port, one combinational read port, reset to zero.
module matvec3_operand_buf
   import matvec_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic signed [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic signed [WIDTH-1:0]  rd_data
);

   logic signed [WIDTH-1:0] mem_q [N_OPS];
   logic signed [WIDTH-1:0] mem_d [N_OPS];

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < N_OPS; i++) begin
         if (wr_en && (wr_addr == ADDR_W'(i))) begin
            mem_d[i] = wr_data;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < N_OPS; i++) begin
         if (rd_addr == ADDR_W'(i)) begin
            rd_data = mem_q[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_OPS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/matvec3_stream_driver.sv
// Streams the 12 buffered operands to the MVM, collects its 3 row results
// for host readback, pulses done and reports the transaction length.
module matvec3_stream_driver
   import matvec_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_wr_en,
   input  logic [ADDR_W-1:0]        cfg_addr,
   input  logic signed [WIDTH-1:0]  cfg_data,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic signed [WIDTH-1:0]  m_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic signed [RES_W-1:0]  s_data,
   input  logic [1:0]               res_addr,
   output logic signed [RES_W-1:0]  res_data,
   output logic [15:0]              cycle_cnt
);

   // Handshake: a word moves on a rising edge where valid && ready; the
   // sender holds valid and data until then, and valid never depends on ready.

   drv_state_t               state_q, state_d;
   logic [ADDR_W-1:0]        send_idx_q, send_idx_d;
   logic [1:0]               rcv_idx_q, rcv_idx_d;
   logic [15:0]              cnt_q, cnt_d;
   logic                     done_q, done_d;
   logic signed [RES_W-1:0]  res_q [ROWS];
   logic signed [RES_W-1:0]  res_d [ROWS];

   logic                     buf_wr_en;
   logic signed [WIDTH-1:0]  buf_rd_data;
   logic [15:0]              cnt_inc;

   // The buffer is frozen once a transaction is under way.
   assign buf_wr_en = (state_q == IDLE) && cfg_wr_en && (cfg_addr < ADDR_W'(N_OPS));

   matvec3_operand_buf u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (buf_wr_en),
      .wr_addr (cfg_addr),
      .wr_data (cfg_data),
      .rd_addr (send_idx_q),
      .rd_data (buf_rd_data)
   );

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;

   always_comb begin
      state_d    = state_q;
      send_idx_d = send_idx_q;
      rcv_idx_d  = rcv_idx_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      res_d      = res_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SEND;
               send_idx_d = '0;
               rcv_idx_d  = '0;
               cnt_d      = '0;
            end
         end
         SEND: begin
            cnt_d = cnt_inc;
            if (m_ready) begin
               send_idx_d = send_idx_q + ADDR_W'(1);
               if (send_idx_q == ADDR_W'(N_OPS - 1)) begin
                  state_d = RECV;
               end
            end
         end
         RECV: begin
            cnt_d = cnt_inc;
            if (s_valid) begin
               for (int i = 0; i < ROWS; i++) begin
                  if (rcv_idx_q == 2'(i)) begin
                     res_d[i] = s_data;
                  end
               end
               rcv_idx_d = rcv_idx_q + 2'd1;
               if (rcv_idx_q == 2'(ROWS - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         send_idx_q <= '0;
         rcv_idx_q  <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         for (int i = 0; i < ROWS; i++) begin
            res_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         send_idx_q <= send_idx_d;
         rcv_idx_q  <= rcv_idx_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         res_q      <= res_d;
      end
   end

   assign m_valid   = (state_q == SEND);
   assign s_ready   = (state_q == RECV);
   assign busy      = (state_q != IDLE);
   assign m_data    = m_valid ? buf_rd_data : '0;
   assign done      = done_q;
   assign cycle_cnt = cnt_q;

   always_comb begin
      res_data = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (res_addr == 2'(i)) begin
            res_data = res_q[i];
         end
      end
   end

endmodule
